// File: rtl/riscv_m_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: decode constants,
// operation codes and FSM states.
package riscv_m_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
   localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } muldiv_state_t;

   // Funct3[2] separates the divide family from the multiply family.
   function automatic logic op_is_div(input muldiv_op_t op);
      return op[2];
   endfunction

   // Funct3[1] within the divide family selects the remainder.
   function automatic logic op_is_rem(input muldiv_op_t op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake and operand bundle between the pipeline and the
// multiply/divide unit.
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            start;
   logic            flush;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic            is_muldiv;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] Result;

   modport master (
      output ALUOp, Funct7, Funct3, start, flush, SrcA, SrcB,
      input  is_muldiv, stall, done, Result
   );

   modport slave (
      input  ALUOp, Funct7, Funct3, start, flush, SrcA, SrcB,
      output is_muldiv, stall, done, Result
   );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply step or
// restoring-divide step over a {hi, lo} double-width register.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
      shifted = {hi_i, lo_i[XLEN-1]};
      diff    = shifted - {1'b0, b_i};
      hi_o    = hi_i;
      lo_o    = lo_i;
      if (is_div_i) begin
         // Partial remainder stays below the divisor, so diff's MSB is its sign.
         if (!diff[XLEN]) begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            hi_o = shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: decodes M instructions, runs XLEN
// shift-add / restoring steps on magnitudes, then fixes up the sign.
module muldiv_unit
   import riscv_m_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);

   localparam int unsigned CntW = $clog2(XLEN + 1);

   muldiv_state_t   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   muldiv_op_t      op_q, op_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_muldiv;
   muldiv_op_t      op_in;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, special, accept, neg_in;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] hi_step, lo_step;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   // Operand decode and sign handling, all relative to the incoming instruction.
   always_comb begin
      is_muldiv = (bus.ALUOp == ALUOP_RTYPE) && (bus.Funct7 == FUNCT7_MULDIV);
      op_in     = muldiv_op_t'(bus.Funct3);
      a_neg     = bus.SrcA[XLEN-1] &&
                  (op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem});
      b_neg     = bus.SrcB[XLEN-1] && (op_in inside {OpMul, OpMulh, OpDiv, OpRem});
      a_mag     = a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
      b_mag     = b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
      neg_in    = op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);

      div_zero  = op_is_div(op_in) && (bus.SrcB == '0);
      div_ovf   = (op_in inside {OpDiv, OpRem}) &&
                  (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == '1);
      special   = div_zero || div_ovf;
      if (div_zero) begin
         special_res = op_is_rem(op_in) ? bus.SrcA : '1;
      end else begin
         special_res = op_is_rem(op_in) ? '0 : bus.SrcA;
      end

      accept = (state_q == IDLE) && bus.start && is_muldiv && !bus.flush;
   end

   muldiv_step #(
      .XLEN (XLEN)
   ) u_step (
      .is_div_i (op_is_div(op_q)),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .b_i      (b_q),
      .hi_o     (hi_step),
      .lo_o     (lo_step)
   );

   // Sign fix-up and half/word select applied in the FIX cycle.
   always_comb begin
      prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
      rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
      unique case (op_q)
         OpMul:                     fix_res = prod_fix[XLEN-1:0];
         OpMulh, OpMulhsu, OpMulhu: fix_res = prod_fix[2*XLEN-1:XLEN];
         OpDiv, OpDivu:             fix_res = quo_fix;
         OpRem, OpRemu:             fix_res = rem_fix;
         default:                   fix_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d  = op_in;
               neg_d = neg_in;
               hi_d  = '0;
               lo_d  = op_is_div(op_in) ? a_mag : b_mag;
               b_d   = op_is_div(op_in) ? b_mag : a_mag;
               if (special) begin
                  result_d = special_res;
                  state_d  = DONE;
               end else begin
                  cnt_d   = CntW'(XLEN);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = fix_res;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A kill abandons the operation without touching the architectural result.
      if (bus.flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OpMul;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         result_q <= result_d;
      end
   end

   assign bus.is_muldiv = is_muldiv;
   // Gated by rst_n so the pipeline is released the moment reset asserts.
   assign bus.stall     = rst_n && (((state_q == IDLE) && bus.start && is_muldiv) ||
                                    (state_q == CALC) || (state_q == FIX));
   assign bus.done      = (state_q == DONE);
   assign bus.Result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, stall window,
// results, special cases, flush, non-M decode and asynchronous reset.
module tb_muldiv_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(
      .XLEN (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Issues one M op at cycle 0 and observes until done; cycle k is sampled
   // 1 time unit after the k-th negedge.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit no_wait, output int done_cyc, output int stall_cnt,
                         output logic [31:0] res);
      done_cyc  = -1;
      stall_cnt = 0;
      res       = 32'h0;
      for (int cyc = 0; cyc < 50 && done_cyc < 0; cyc++) begin
         if (cyc > 0 || !no_wait) @(negedge clk);
         if (cyc == 0) begin
            bus.ALUOp  = 2'b10;
            bus.Funct7 = 7'b0000001;
            bus.Funct3 = f3;
            bus.SrcA   = a;
            bus.SrcB   = b;
            bus.start  = 1'b1;
         end else begin
            bus.start = 1'b0;
            bus.SrcA  = ~a;
            bus.SrcB  = ~b;
         end
         #1;
         if (bus.stall) stall_cnt++;
         if (bus.done) begin
            done_cyc = cyc;
            res      = bus.Result;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.ALUOp = 2'b00; bus.Funct7 = 7'h0; bus.Funct3 = 3'h0;
      bus.start = 1'b0;  bus.flush = 1'b0;  bus.SrcA = '0; bus.SrcB = '0;
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.Result !== 32'h0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset: Result=%h done=%b stall=%b, want 0/0/0",
                  bus.Result, bus.done, bus.stall);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic test_mul();
      int dc, sc;
      logic [31:0] r;
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, dc, sc, r);
      n_vec++;
      if (dc !== 34) begin n_err++; $display("FAIL mul_done_cycle: got %0d want 34", dc); end
      n_vec++;
      if (sc !== 34) begin n_err++; $display("FAIL mul_stall_cycles: got %0d want 34", sc); end
      n_vec++;
      if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h want ffffffeb", r); end
      @(negedge clk); #1;
      n_vec++;
      if (bus.done !== 1'b0 || bus.Result !== 32'hFFFF_FFEB) begin
         n_err++;
         $display("FAIL mul_after_done: done=%b Result=%h want 0/ffffffeb", bus.done, bus.Result);
      end
   endtask

   task automatic test_mulh();
      logic [2:0]  f3 [3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] va [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] vb [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      int dc, sc;
      logic [31:0] r;
      for (int i = 0; i < 3; i++) begin
         run_op(f3[i], va[i], vb[i], 1'b0, dc, sc, r);
         n_vec++;
         if (dc !== 34 || sc !== 34) begin
            n_err++;
            $display("FAIL mulh[%0d]_timing: done=%0d stall=%0d want 34/34", i, dc, sc);
         end
         n_vec++;
         if (r !== ex[i]) begin
            n_err++;
            $display("FAIL mulh[%0d]_result: got %h want %h", i, r, ex[i]);
         end
      end
   endtask

   task automatic test_special();
      logic [2:0]  f3 [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] va [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
      int dc, sc;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         run_op(f3[i], va[i], vb[i], 1'b0, dc, sc, r);
         n_vec++;
         if (dc !== 1 || sc !== 1) begin
            n_err++;
            $display("FAIL special[%0d]_timing: done=%0d stall=%0d want 1/1", i, dc, sc);
         end
         n_vec++;
         if (r !== ex[i]) begin
            n_err++;
            $display("FAIL special[%0d]_result: got %h want %h", i, r, ex[i]);
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] vb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int dc, sc;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         run_op(f3[i], va[i], vb[i], 1'b0, dc, sc, r);
         n_vec++;
         if (dc !== 34 || sc !== 34) begin
            n_err++;
            $display("FAIL div[%0d]_timing: done=%0d stall=%0d want 34/34", i, dc, sc);
         end
         n_vec++;
         if (r !== ex[i]) begin
            n_err++;
            $display("FAIL div[%0d]_result: got %h want %h", i, r, ex[i]);
         end
      end
   endtask

   // Result going in is 2, left by the preceding REMU 100/7.
   task automatic test_flush();
      int dc, sc, done_seen;
      logic [31:0] r;
      done_seen = 0;
      for (int cyc = 0; cyc <= 11; cyc++) begin
         @(negedge clk);
         bus.start  = (cyc == 0);
         bus.flush  = (cyc == 10);
         bus.ALUOp  = 2'b10;
         bus.Funct7 = 7'b0000001;
         bus.Funct3 = 3'b000;
         bus.SrcA   = 32'd123;
         bus.SrcB   = 32'd456;
         #1;
         if (bus.done) done_seen++;
      end
      n_vec++;
      if (bus.stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
      n_vec++;
      if (done_seen !== 0) begin n_err++; $display("FAIL flush_done: got %0d want 0", done_seen); end
      n_vec++;
      if (bus.Result !== 32'd2) begin
         n_err++;
         $display("FAIL flush_result_kept: got %h want 00000002", bus.Result);
      end
      run_op(3'b101, 32'd100, 32'd7, 1'b1, dc, sc, r);
      n_vec++;
      if (dc !== 34 || sc !== 34 || r !== 32'd14) begin
         n_err++;
         $display("FAIL flush_then_div: done=%0d stall=%0d Result=%h want 34/34/0000000e",
                  dc, sc, r);
      end
   endtask

   task automatic test_non_m();
      int dc, sc, bad;
      logic [31:0] r;
      bad = 0;
      @(negedge clk);
      bus.ALUOp = 2'b10; bus.Funct7 = 7'h00; bus.Funct3 = 3'b000; bus.start = 1'b1;
      #1;
      n_vec++;
      if (bus.is_muldiv !== 1'b0) begin n_err++; $display("FAIL nonm_decode: got %b want 0", bus.is_muldiv); end
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         bus.ALUOp  = (cyc[0]) ? 2'b00 : 2'b10;
         bus.Funct7 = (cyc[0]) ? 7'b0000001 : 7'h20;
         #1;
         if (bus.is_muldiv || bus.stall || bus.done) bad++;
      end
      bus.start = 1'b0;
      n_vec++;
      if (bad !== 0) begin n_err++; $display("FAIL nonm_quiet: got %0d active cycles want 0", bad); end
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, dc, sc, r);
      n_vec++;
      if (dc !== 34 || sc !== 34 || r !== 32'hFFFF_FFEB) begin
         n_err++;
         $display("FAIL nonm_then_mul: done=%0d stall=%0d Result=%h want 34/34/ffffffeb",
                  dc, sc, r);
      end
   endtask

   // Result going in is 0xFFFFFFEB from the preceding MUL.
   task automatic test_reset_mid();
      int dc, sc;
      logic [31:0] r;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         @(negedge clk);
         bus.ALUOp = 2'b10; bus.Funct7 = 7'b0000001; bus.Funct3 = 3'b100;
         bus.SrcA  = 32'd100; bus.SrcB = 32'd7;
         bus.start = (cyc == 0);
         #1;
      end
      n_vec++;
      if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: stall=%b want 1", bus.stall); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.Result !== 32'h0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_immediate: Result=%h done=%b stall=%b want 0/0/0",
                  bus.Result, bus.done, bus.stall);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      run_op(3'b111, 32'd100, 32'd7, 1'b0, dc, sc, r);
      n_vec++;
      if (dc !== 34 || sc !== 34 || r !== 32'd2) begin
         n_err++;
         $display("FAIL rstmid_then_remu: done=%0d stall=%0d Result=%h want 34/34/00000002",
                  dc, sc, r);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_special();
      test_div();
      test_flush();
      test_non_m();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
